ahb_lite_decoder_mux: RTL and testbench

AHB-Lite address decoder and slave-response multiplexer sitting directly upstream of the default slave and the peripheral slaves. It decodes the master's address-phase HADDR into one-hot slave selects. Any transfer that hits no region is routed to the default slave via HSEL_DEF. A data-phase select register steers the selected slave's HRDATA/HREADYOUT/HRESP back to the master; an optional error log records unmapped accesses.

---
 rtl/ahb_lite_decoder_mux.sv | 156 +++++++++++++++
 tb/tb_ahb_lite_decoder_mux.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_decoder_mux.sv
// AHB-Lite address decoder and slave-response multiplexer with optional
// unmapped-access error log, built when AHB_DEC_ERRLOG_EN is defined.

module ahb_dec_cmp #(
  parameter logic [31:0] BASE = 32'h0,
  parameter logic [31:0] MASK = 32'h0
) (
  input  logic [31:0] addr,
  output logic        hit
);
  assign hit = ((addr ^ BASE) & MASK) == 32'h0;
endmodule

module ahb_lite_decoder_mux #(
  parameter int                    NUM_SLV  = 3,
  parameter logic [32*NUM_SLV-1:0] SLV_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLV-1:0] SLV_MASK = {3{32'hF000_0000}}
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  output logic                    HREADY,
  output logic [NUM_SLV-1:0]      HSEL,
  output logic                    HSEL_DEF,
  input  logic [32*NUM_SLV-1:0]   S_HRDATA,
  input  logic [NUM_SLV-1:0]      S_HREADYOUT,
  input  logic [2*NUM_SLV-1:0]    S_HRESP,
  input  logic [31:0]             D_HRDATA,
  input  logic                    D_HREADYOUT,
  input  logic [1:0]              D_HRESP,
  output logic [31:0]             HRDATA,
  output logic [1:0]              HRESP,
  input  logic                    ERR_CLR,
  output logic                    ERR_VALID,
  output logic [31:0]             ERR_ADDR,
  output logic [7:0]              ERR_CNT
);
  localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  localparam logic [1:0] D_NONE = 2'd0;
  localparam logic [1:0] D_SLV  = 2'd1;
  localparam logic [1:0] D_DEF  = 2'd2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic [1:0]  resp;
  } rsp_t;

  logic [NUM_SLV-1:0]       hit;
  logic [NUM_SLV-1:0]       sel;
  logic [IW-1:0]            sel_idx;
  logic                     found;
  logic [1:0]               dsel_kind;
  logic [IW-1:0]            dsel_idx;
  logic [NUM_SLV-1:0][31:0] s_rdata;
  logic [NUM_SLV-1:0][1:0]  s_resp;
  rsp_t                     rsp;
  logic                     unused;

  genvar g;
  generate
    for (g = 0; g < NUM_SLV; g++) begin : g_cmp
      ahb_dec_cmp #(
        .BASE (SLV_BASE[32*g +: 32]),
        .MASK (SLV_MASK[32*g +: 32])
      ) u_cmp (
        .addr (HADDR),
        .hit  (hit[g])
      );
    end
  endgenerate

  // Lowest index wins on overlapping regions, keeping HSEL one-hot.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (hit[i] && !found) begin
        sel[i]  = 1'b1;
        sel_idx = IW'(i);
        found   = 1'b1;
      end
    end
  end

  assign HSEL     = sel;
  assign HSEL_DEF = ~found;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_kind <= D_NONE;
      dsel_idx  <= '0;
    end else if (HREADY) begin
      if (!HTRANS[1]) begin
        dsel_kind <= D_NONE;
        dsel_idx  <= '0;
      end else if (found) begin
        dsel_kind <= D_SLV;
        dsel_idx  <= sel_idx;
      end else begin
        dsel_kind <= D_DEF;
        dsel_idx  <= '0;
      end
    end
  end

  assign s_rdata = S_HRDATA;
  assign s_resp  = S_HRESP;

  always_comb begin
    rsp = '{rdata: 32'h0, ready: 1'b1, resp: 2'b00};
    case (dsel_kind)
      D_SLV:   rsp = '{rdata: s_rdata[dsel_idx], ready: S_HREADYOUT[dsel_idx], resp: s_resp[dsel_idx]};
      D_DEF:   rsp = '{rdata: D_HRDATA, ready: D_HREADYOUT, resp: D_HRESP};
      default: ;
    endcase
  end

  assign HRDATA = rsp.rdata;
  assign HREADY = rsp.ready;
  assign HRESP  = rsp.resp;

`ifdef AHB_DEC_ERRLOG_EN
  logic err_hit;
  assign err_hit = HREADY & HTRANS[1] & ~found;

  // A new error outranks a coincident clear: the log restarts at one.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= 32'h0;
      ERR_CNT   <= 8'h0;
    end else if (err_hit) begin
      ERR_VALID <= 1'b1;
      ERR_ADDR  <= HADDR;
      if (ERR_CLR)             ERR_CNT <= 8'h1;
      else if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'h1;
    end else if (ERR_CLR) begin
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= 32'h0;
      ERR_CNT   <= 8'h0;
    end
  end
`else
  assign ERR_VALID = 1'b0;
  assign ERR_ADDR  = 32'h0;
  assign ERR_CNT   = 8'h0;
`endif

  // HTRANS[0] never affects decode; ERR_CLR is idle without the log.
  assign unused = ^{HTRANS[0], ERR_CLR};

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// Directed bench for ahb_lite_decoder_mux: a target-level model checked every
// cycle, plus literal expectations taken from the block's test plan.

module tb_ahb_lite_decoder_mux;
  localparam int N = 3;
`ifdef AHB_DEC_ERRLOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HREADY;
  logic [N-1:0]      HSEL;
  logic              HSEL_DEF;
  logic [N-1:0][31:0] s_rdata;
  logic [N-1:0]      s_rdy;
  logic [N-1:0][1:0] s_resp;
  logic [31:0]       D_HRDATA;
  logic              D_HREADYOUT;
  logic [1:0]        D_HRESP;
  logic [31:0]       HRDATA;
  logic [1:0]        HRESP;
  logic              ERR_CLR;
  logic              ERR_VALID;
  logic [31:0]       ERR_ADDR;
  logic [7:0]        ERR_CNT;

  ahb_lite_decoder_mux #(.NUM_SLV(N)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HREADY      (HREADY),
    .HSEL        (HSEL),
    .HSEL_DEF    (HSEL_DEF),
    .S_HRDATA    (s_rdata),
    .S_HREADYOUT (s_rdy),
    .S_HRESP     (s_resp),
    .D_HRDATA    (D_HRDATA),
    .D_HREADYOUT (D_HREADYOUT),
    .D_HRESP     (D_HRESP),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .ERR_CLR     (ERR_CLR),
    .ERR_VALID   (ERR_VALID),
    .ERR_ADDR    (ERR_ADDR),
    .ERR_CNT     (ERR_CNT)
  );

  always #5 HCLK = ~HCLK;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Memory map: slave i owns the 256 MB window at i*0x1000_0000.
  logic [31:0] base [N] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000};
  logic [31:0] mask = 32'hF000_0000;

  // Model state: -1 no data phase, 0..N-1 slave, N default slave.
  int          m_tgt = -1;
  bit          m_valid = 1'b0;
  logic [31:0] m_addr = 32'h0;
  int          m_cnt = 0;

  function automatic int decode(logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & mask) == (base[i] & mask)) return i;
    return N;
  endfunction

  function automatic logic exp_rdy();
    if (m_tgt < 0)  return 1'b1;
    if (m_tgt == N) return D_HREADYOUT;
    return s_rdy[m_tgt];
  endfunction

  function automatic logic [1:0] exp_resp();
    if (m_tgt < 0)  return 2'b00;
    if (m_tgt == N) return D_HRESP;
    return s_resp[m_tgt];
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (m_tgt < 0)  return 32'h0;
    if (m_tgt == N) return D_HRDATA;
    return s_rdata[m_tgt];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    int d;
    logic [31:0] e_hsel;
    if (chk_en) begin
      d = decode(HADDR);
      e_hsel = 32'h0;
      if (d < N) e_hsel[d] = 1'b1;
      check("hsel",      {29'h0, HSEL}, e_hsel);
      check("hsel_def",  {31'h0, HSEL_DEF}, {31'h0, d == N});
      check("hready",    {31'h0, HREADY}, {31'h0, exp_rdy()});
      check("hresp",     {30'h0, HRESP}, {30'h0, exp_resp()});
      check("hrdata",    HRDATA, exp_rdata());
      check("err_valid", {31'h0, ERR_VALID}, LOG ? {31'h0, m_valid} : 32'h0);
      check("err_addr",  ERR_ADDR, LOG ? m_addr : 32'h0);
      check("err_cnt",   {24'h0, ERR_CNT}, LOG ? 32'(m_cnt) : 32'h0);
    end
  end

  always @(posedge HCLK) begin
    int d;
    logic rdy;
    d = decode(HADDR);
    rdy = exp_rdy();
    if (HRESET) begin
      m_tgt = -1; m_valid = 1'b0; m_addr = 32'h0; m_cnt = 0;
    end else begin
      if (rdy && HTRANS[1] && d == N) begin
        m_valid = 1'b1;
        m_addr  = HADDR;
        m_cnt   = ERR_CLR ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (ERR_CLR) begin
        m_valid = 1'b0; m_addr = 32'h0; m_cnt = 0;
      end
      if (rdy) m_tgt = HTRANS[1] ? d : -1;
    end
  end

  task automatic cyc();
    @(posedge HCLK);
    #2;
  endtask

  logic [31:0] tbl [8] = '{32'h0000_0010, 32'h1000_0020, 32'h2000_0030, 32'h7000_0000,
                           32'h1FFF_FFFC, 32'h2FFF_FFFC, 32'h0FFF_FFFC, 32'hF000_0000};

  initial begin
    HRESET = 1'b1; HADDR = 32'h0; HTRANS = 2'b00; ERR_CLR = 1'b0;
    s_rdata[0] = 32'h0000_AAAA; s_rdata[1] = 32'h1111_1111; s_rdata[2] = 32'h2222_0002;
    s_rdy = '1; s_resp = '0;
    D_HRDATA = 32'hDEAD_0000; D_HREADYOUT = 1'b1; D_HRESP = 2'b00;

    cyc(); chk_en = 1'b1;
    cyc(); HRESET = 1'b0; #1;
    check("rst_hready", {31'h0, HREADY}, 32'h1);
    check("rst_hresp",  {30'h0, HRESP}, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_errcnt", {24'h0, ERR_CNT}, 32'h0);

    // Read from slave1 with one wait state
    HADDR = 32'h1000_0040; HTRANS = 2'b10; #1;
    check("rd_hsel", {29'h0, HSEL}, 32'h2);
    cyc(); HTRANS = 2'b00; HADDR = 32'h0; s_rdy[1] = 1'b0; #1;
    check("rd_wait", {31'h0, HREADY}, 32'h0);
    cyc(); s_rdy[1] = 1'b1; s_rdata[1] = 32'hCAFE_0001; #1;
    check("rd_done",  {31'h0, HREADY}, 32'h1);
    check("rd_data",  HRDATA, 32'hCAFE_0001);

    // Unmapped write answered by the default slave with a two-cycle ERROR
    cyc(); HADDR = 32'h3000_0000; HTRANS = 2'b10; #1;
    check("um_hsel_def", {31'h0, HSEL_DEF}, 32'h1);
    check("um_hsel",     {29'h0, HSEL}, 32'h0);
    cyc(); HTRANS = 2'b00; D_HREADYOUT = 1'b0; D_HRESP = 2'b01; #1;
    check("um_err1_rdy",  {31'h0, HREADY}, 32'h0);
    check("um_err1_resp", {30'h0, HRESP}, 32'h1);
    check("um_log_addr",  ERR_ADDR, LOG ? 32'h3000_0000 : 32'h0);
    check("um_log_cnt",   {24'h0, ERR_CNT}, LOG ? 32'h1 : 32'h0);
    cyc(); D_HREADYOUT = 1'b1; #1;
    check("um_err2_rdy",  {31'h0, HREADY}, 32'h1);
    check("um_err2_resp", {30'h0, HRESP}, 32'h1);
    cyc(); D_HRESP = 2'b00;

    // Back-to-back slave0 then slave2
    HADDR = 32'h0000_0000; HTRANS = 2'b10;
    cyc(); HADDR = 32'h2000_0004; HTRANS = 2'b11; #1;
    check("b2b_s0", HRDATA, 32'h0000_AAAA);
    cyc(); HADDR = 32'h3000_0000; HTRANS = 2'b00; #1;
    check("b2b_s2", HRDATA, 32'h2222_0002);
    check("b2b_rdy", {31'h0, HREADY}, 32'h1);
    cyc(); #1;
    check("idle_rdy",  {31'h0, HREADY}, 32'h1);
    check("idle_resp", {30'h0, HRESP}, 32'h0);
    check("idle_cnt",  {24'h0, ERR_CNT}, LOG ? 32'h1 : 32'h0);

    // Reset while slave1 holds a wait state
    HADDR = 32'h1000_0000; HTRANS = 2'b10;
    cyc(); HTRANS = 2'b00; s_rdy[1] = 1'b0; HRESET = 1'b1; #1;
    check("mrst_wait", {31'h0, HREADY}, 32'h0);
    cyc(); HRESET = 1'b0; #1;
    check("mrst_rdy", {31'h0, HREADY}, 32'h1);
    check("mrst_cnt", {24'h0, ERR_CNT}, 32'h0);
    cyc(); s_rdy[1] = 1'b1;

    // Mixed targets with assorted wait states, checked by the model
    for (int i = 0; i < 8; i++) begin
      HADDR = tbl[i]; HTRANS = (i % 2 == 0) ? 2'b10 : 2'b11;
      s_rdy = (i % 3 == 0) ? 3'b101 : 3'b111;
      D_HREADYOUT = i[0];
      s_rdata[i % N] = 32'h5A00_0000 + 32'(i);
      cyc();
    end
    s_rdy = '1; D_HREADYOUT = 1'b1; HTRANS = 2'b00;
    cyc(); cyc();

    // Saturate the error counter
    for (int i = 0; i < 256; i++) begin
      HADDR = 32'h5000_0000 + 32'(i * 4); HTRANS = 2'b10;
      cyc();
    end
    HTRANS = 2'b00; #1;
    check("sat_cnt", {24'h0, ERR_CNT}, LOG ? 32'hFF : 32'h0);

    // Clear coincident with a new error: error wins
    cyc(); ERR_CLR = 1'b1; HADDR = 32'h4000_0010; HTRANS = 2'b10;
    cyc(); ERR_CLR = 1'b0; HTRANS = 2'b00; #1;
    check("clr_err_cnt",   {24'h0, ERR_CNT}, LOG ? 32'h1 : 32'h0);
    check("clr_err_addr",  ERR_ADDR, LOG ? 32'h4000_0010 : 32'h0);
    check("clr_err_valid", {31'h0, ERR_VALID}, LOG ? 32'h1 : 32'h0);
    cyc(); HADDR = 32'h0; ERR_CLR = 1'b1;
    cyc(); ERR_CLR = 1'b0; #1;
    check("clr_valid", {31'h0, ERR_VALID}, 32'h0);
    check("clr_cnt",   {24'h0, ERR_CNT}, 32'h0);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
